// File: rtl/i2s_audio_rx.sv
// rtl/i2s_audio_rx.sv - I2S receiver: deserializes sck/lrck/sdin into 16-bit L/R sample pairs
//
// Optional feature macro: I2S_RX_PEAK_EN (peak-level tracking with decay).
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   en                 receiver enable; low clears framing state, outputs hold
//   sck, lrck, sdin    external I2S pins, asynchronous to clk
//   left_sample        last complete left word
//   right_sample       last complete right word
//   sample_valid       one-clk pulse when both samples update together
//   frame_err          one-clk pulse on a short slot
//   frame_cnt          number of valid pairs delivered (wraps)
//   peak_left/right    peak magnitudes (0 when the peak feature is disabled)
module i2s_audio_rx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sck,
    input  logic             lrck,
    input  logic             sdin,
    output logic [WIDTH-1:0] left_sample,
    output logic [WIDTH-1:0] right_sample,
    output logic             sample_valid,
    output logic             frame_err,
    output logic [15:0]      frame_cnt,
    output logic [WIDTH-1:0] peak_left,
    output logic [WIDTH-1:0] peak_right
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic sck_s1, sck_s2, sck_s3;
    logic lrck_s1, lrck_s2;
    logic sdin_s1, sdin_s2;

    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] left_stage;
    logic [WIDTH-1:0] right_hold;
    logic             lrck_prev;
    logic             left_ok;
    logic             armed;
    logic             pair_pend;

    logic             strobe;
    logic             lr_changed;
    logic             slot_short;
    logic [WIDTH-1:0] word;

    assign strobe     = sck_s2 & ~sck_s3;
    assign lr_changed = lrck_s2 != lrck_prev;

    // Word assembled at slot end. With exactly WIDTH-1 bits shifted, the
    // bit arriving with the lrck change is the LSB; with WIDTH or more the
    // word is already complete and the current bit is surplus.
    always_comb begin
        word       = sr;
        slot_short = 1'b0;
        if (bit_cnt == CNT_LAST) begin
            word = {sr[WIDTH-2:0], sdin_s2};
        end else if (bit_cnt < CNT_LAST) begin
            slot_short = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            sdin_s1 <= 1'b0;
            sdin_s2 <= 1'b0;
        end else begin
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            lrck_s1 <= lrck;
            lrck_s2 <= lrck_s1;
            sdin_s1 <= sdin;
            sdin_s2 <= sdin_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr           <= '0;
            bit_cnt      <= '0;
            left_stage   <= '0;
            right_hold   <= '0;
            lrck_prev    <= 1'b0;
            left_ok      <= 1'b0;
            armed        <= 1'b0;
            pair_pend    <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            // The pair is published one clk after the right word closes so
            // both samples and the strobe change together.
            if (pair_pend) begin
                left_sample  <= left_stage;
                right_sample <= right_hold;
                sample_valid <= 1'b1;
                frame_cnt    <= frame_cnt + 16'd1;
                pair_pend    <= 1'b0;
            end

            if (!en) begin
                bit_cnt <= '0;
                armed   <= 1'b0;
                left_ok <= 1'b0;
            end else if (strobe) begin
                if (!lr_changed) begin
                    if (bit_cnt < CNT_FULL) begin
                        sr      <= {sr[WIDTH-2:0], sdin_s2};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    bit_cnt   <= '0;
                    lrck_prev <= lrck_s2;
                    if (!armed) begin
                        // First boundary after reset/enable: slot contents unknown.
                        armed <= 1'b1;
                    end else if (slot_short) begin
                        frame_err <= 1'b1;
                        if (!lrck_prev) begin
                            left_ok <= 1'b0;
                        end
                    end else if (!lrck_prev) begin
                        left_stage <= word;
                        left_ok    <= 1'b1;
                    end else if (left_ok) begin
                        right_hold <= word;
                        pair_pend  <= 1'b1;
                        left_ok    <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef I2S_RX_PEAK_EN
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        if (!x[WIDTH-1]) begin
            return x;
        end else if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            return -x;
        end
    endfunction

    logic             decay;
    logic [WIDTH-1:0] base_left, base_right;
    logic [WIDTH-1:0] mag_left, mag_right;

    // frame_cnt low byte at 0xFF means this publish is the 256th pair.
    assign decay      = frame_cnt[7:0] == 8'hFF;
    assign base_left  = decay ? (peak_left >> 1) : peak_left;
    assign base_right = decay ? (peak_right >> 1) : peak_right;
    assign mag_left   = mag(left_stage);
    assign mag_right  = mag(right_hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (pair_pend) begin
            peak_left  <= (mag_left > base_left) ? mag_left : base_left;
            peak_right <= (mag_right > base_right) ? mag_right : base_right;
        end
    end
`else
    assign peak_left  = '0;
    assign peak_right = '0;
`endif

endmodule

// File: tb/tb_i2s_audio_rx.sv
// tb/tb_i2s_audio_rx.sv - self-checking bench for i2s_audio_rx (table vectors + scoreboard)
module tb_i2s_audio_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sck;
    logic        lrck;
    logic        sdin;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [15:0] peak_left;
    logic [15:0] peak_right;

    i2s_audio_rx #(.WIDTH(16), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sck          (sck),
        .lrck         (lrck),
        .sdin         (sdin),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt),
        .peak_left    (peak_left),
        .peak_right   (peak_right)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          nl;
        int          nr;
        bit          v;
        bit          e;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pair_left", {16'd0, left_sample}, {16'd0, e[31:16]});
                check("pair_right", {16'd0, right_sample}, {16'd0, e[15:0]});
            end
            if (frame_err) check("valid_and_err", 32'd1, 32'd0);
        end
        if (frame_err) err_seen++;
    end

    task automatic emit_bit(input logic lr, input logic d, input int half);
        sck  = 1'b0;
        lrck = lr;
        sdin = d;
        repeat (half) @(negedge clk);
        sck = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    // One L+R frame. The data stream lags lrck by one bit; the bit that
    // opened this frame was sent as the trailing bit of the previous call.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int nl, input int nr, input int half);
        logic bits[$];
        logic lrs[$];
        int   total;
        for (int i = 0; i < nl; i++) begin
            bits.push_back(i < 16 ? l[15-i] : 1'b0);
            lrs.push_back(1'b0);
        end
        for (int i = 0; i < nr; i++) begin
            bits.push_back(i < 16 ? r[15-i] : 1'b0);
            lrs.push_back(1'b1);
        end
        total = nl + nr;
        for (int g = 1; g <= total; g++) begin
            emit_bit((g < total) ? lrs[g] : 1'b0, bits[g-1], half);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        sck  = 1'b0;
        lrck = 1'b0;
        sdin = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_left", {16'd0, left_sample}, 32'd0);
        check("rst_right", {16'd0, right_sample}, 32'd0);
        check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        tbl[0] = '{16'h1234, 16'hABCD, 16, 16, 1'b0, 1'b0};
        tbl[1] = '{16'h1234, 16'hABCD, 16, 16, 1'b1, 1'b0};
        tbl[2] = '{16'h1234, 16'hABCD, 16, 16, 1'b1, 1'b0};
        tbl[3] = '{16'h8001, 16'h7FFF, 32, 32, 1'b1, 1'b0};
        tbl[4] = '{16'h1111, 16'h2222, 16, 16, 1'b1, 1'b0};
        tbl[5] = '{16'h3333, 16'h4444, 16, 10, 1'b0, 1'b1};
        tbl[6] = '{16'h5555, 16'h6666, 16, 16, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'hFFFF, 20, 17, 1'b1, 1'b0};

        begin
            int exp_err;
            int exp_cnt;
            exp_err = 0;
            exp_cnt = 0;
            for (int i = 0; i < 8; i++) begin
                if (tbl[i].v) begin
                    exp_q.push_back({tbl[i].l, tbl[i].r});
                    exp_cnt++;
                end
                if (tbl[i].e) exp_err++;
                send_frame(tbl[i].l, tbl[i].r, tbl[i].nl, tbl[i].nr, 8);
                check("vec_err_count", err_seen, exp_err);
                check("vec_frame_cnt", {16'd0, frame_cnt}, exp_cnt);
                check("vec_sb_drained", exp_q.size(), 32'd0);
            end
        end

        // Reset in the middle of a left slot.
        for (int i = 0; i < 5; i++) emit_bit(1'b0, 1'($urandom_range(0, 1)), 8);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_left", {16'd0, left_sample}, 32'd0);
        check("mid_rst_right", {16'd0, right_sample}, 32'd0);
        check("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        err_seen = 0;
        send_frame(16'h9876, 16'h5432, 16, 16, 8);
        check("rearm_no_pair", {16'd0, frame_cnt}, 32'd0);
        exp_q.push_back({16'h9876, 16'h5432});
        send_frame(16'h9876, 16'h5432, 16, 16, 8);
        check("rearm_cnt", {16'd0, frame_cnt}, 32'd1);
        check("rearm_sb_drained", exp_q.size(), 32'd0);

        // Receiver disabled for two frames.
        en = 1'b0;
        send_frame(16'h0BAD, 16'h0BAD, 16, 16, 8);
        send_frame(16'h0BAD, 16'h0BAD, 16, 16, 8);
        check("dis_left_hold", {16'd0, left_sample}, 32'h9876);
        check("dis_right_hold", {16'd0, right_sample}, 32'h5432);
        check("dis_cnt_hold", {16'd0, frame_cnt}, 32'd1);
        en = 1'b1;
        send_frame(16'hAAAA, 16'h5555, 16, 16, 8);
        check("en_arm_only", {16'd0, frame_cnt}, 32'd1);
        exp_q.push_back({16'h0F0F, 16'hF0F0});
        send_frame(16'h0F0F, 16'hF0F0, 16, 16, 8);
        check("en_cnt", {16'd0, frame_cnt}, 32'd2);
        check("en_sb_drained", exp_q.size(), 32'd0);
        check("late_err_count", err_seen, 32'd0);

`ifdef I2S_RX_PEAK_EN
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_frame(16'd0, 16'd0, 16, 16, 4);
        exp_q.push_back({16'd100, 16'd0});
        send_frame(16'd100, 16'd0, 16, 16, 4);
        exp_q.push_back({16'hF448, 16'd0});
        send_frame(16'hF448, 16'd0, 16, 16, 4);
        exp_q.push_back({16'd500, 16'd0});
        send_frame(16'd500, 16'd0, 16, 16, 4);
        check("peak_left_max", {16'd0, peak_left}, 32'd3000);
        check("peak_right_zero", {16'd0, peak_right}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(32'd0);
            send_frame(16'd0, 16'd0, 16, 16, 4);
        end
        check("peak_left_decay", {16'd0, peak_left}, 32'd1500);
        check("peak_cnt", {16'd0, frame_cnt}, 32'd259);
`else
        check("peak_left_off", {16'd0, peak_left}, 32'd0);
        check("peak_right_off", {16'd0, peak_right}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_audio_rx.md
Name: i2s_audio_rx

Overview:
Receive-side counterpart of the on-board I2S speaker serializer. Deserializes an external I2S stream (sck/lrck/sdin), for example from the ADC/line-in of the audio Pmod or a loopback of the speaker path. Outputs 16-bit signed left/right sample pairs in the clk domain with a one-cycle valid strobe. Flags malformed slots. The game logic uses it as a sound-level input, and the bench uses it as a checker for the transmit path.

Parameters:
WIDTH, 16, sample width in bits, MSB first, two's complement
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH+1

Ports:
clk  in  1  system clock (100 MHz); must be at least 6x the sck frequency
rst  in  1  asynchronous, active-high reset
en  in  1  receiver enable; low = idle (counters cleared, outputs held)
sck  in  1  external serial bit clock, asynchronous to clk
lrck  in  1  word select, asynchronous; 0 = left slot, 1 = right slot
sdin  in  1  serial data, asynchronous
left_sample  out  WIDTH  last complete left word
right_sample  out  WIDTH  last complete right word
sample_valid  out  1  one-clk pulse; left/right_sample updated together
frame_err  out  1  one-clk pulse; a short slot was detected
frame_cnt  out  16  count of valid pairs, wraps 0xFFFF->0
peak_left  out  WIDTH  peak |left|; feature-dependent
peak_right  out  WIDTH  peak |right|; feature-dependent

Behaviour:
- Reset: all outputs 0. Shift register, bit_cnt, left staging, lrck_prev, left_ok and armed are all cleared.
- Synchronization: sck, lrck and sdin each pass through a 2-flop synchronizer. A third sck flop provides edge detection.
- Bit strobe: fires on a synchronized sck rising edge (0->1). It is detected 3 clk after the pin edge. lrck_s and sdin_s are sampled on the strobe clk only.
- Framing follows standard I2S with a 1-bit delay. The bit on the strobe where lrck_s != lrck_prev is the LSB of the previous slot's word.
- Strobe, lrck unchanged:
  - if bit_cnt < WIDTH: shift sdin into the LSB of sr, then bit_cnt++.
  - otherwise: ignore the bit (extra slot bits allowed; bit_cnt saturates at WIDTH).
- Strobe, lrck changed (slot end for channel lrck_prev):
  - bit_cnt == WIDTH-1: word = {sr[WIDTH-2:0], sdin_s}.
  - bit_cnt >= WIDTH: word = sr[WIDTH-1:0], and the current bit is discarded.
  - bit_cnt < WIDTH-1: short slot. Pulse frame_err (if armed); no word.
  - In all three cases: bit_cnt <= 0, lrck_prev <= lrck_s.
- Armed flag: the first lrck change after reset or en rise sets armed. That change produces no word and no error.
- Left word (lrck_prev = 0): latch into left staging and set left_ok. A short left slot clears left_ok.
- Right word (lrck_prev = 1):
  - if left_ok: on the next clk, update left_sample <= staging and right_sample <= word, pulse sample_valid, increment frame_cnt, and clear left_ok.
  - otherwise: drop the right word silently.
- Latency: from the pin sck edge that completes the right word to the sample_valid pulse is 4 clk.
- en low: bit_cnt, armed and left_ok are cleared, and no strobes are processed. Sample outputs, frame_cnt and peaks hold their values.
- Simultaneous events: sample_valid and frame_err can never pulse in the same clk, because there is one slot end per strobe.
- sck glitch shorter than 2 clk: may be missed. This is not required to be detected.

Optional Feature:
I2S_RX_PEAK_EN
- Defined:
  - On each sample_valid, peak_x <= max(peak_x, |sample_x|), with |-2^(WIDTH-1)| saturated to 2^(WIDTH-1)-1.
  - Every 256th valid pair, both peaks are first right-shifted by 1 (decay), then the max is applied.
- Undefined: peak_left/peak_right are tied to 0 and no peak logic is synthesized.

Test Plan:
- Reset, then 3 I2S frames: L=0x1234, R=0xABCD, 16 sck per half, sck = clk/16 -> 2 sample_valid pulses (the first frame only arms), left_sample=0x1234, right_sample=0xABCD, frame_cnt=2, frame_err never asserted.
- 32 sck per half, L=0x8001, R=0x7FFF -> words captured from the first 16 bits; left=0x8001, right=0x7FFF; extra bits ignored.
- Right slot truncated to 10 bits -> frame_err one-clk pulse, no sample_valid for that frame; the next good frame gives a valid pair.
- Assert rst mid-left-slot, then release -> outputs are 0; the first subsequent lrck change only arms; the first valid pair arrives after one complete L+R.
- en low for 2 frames, then high -> no sample_valid during low; outputs keep their old values; the first pair after re-arm is correct.
- With I2S_RX_PEAK_EN: L sequence 100, -3000, 500 -> peak_left=3000; after 256 pairs of 0 -> peak_left=1500.
